// File: rtl/ps2_pkg.sv
// Shared types and constants for the PS/2 set-2 scancode filter.
// No logic, so no latency.
// No flow control lives here.
package ps2_pkg;

  // Prefix-FSM state encoding
  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    EXT     = 2'd1,
    BRK     = 2'd2,
    EXT_BRK = 2'd3
  } state_t;

  localparam logic [7:0] PS2_EXT = 8'hE0;
  localparam logic [7:0] PS2_BRK = 8'hF0;

  // One queued key event: extended flag above the make code
  typedef struct packed {
    logic       ext;
    logic [7:0] code;
  } key_evt_t;

  // Controller/status bytes that never describe a key
  function automatic logic is_special(input logic [7:0] b);
    case (b)
      8'h00, 8'hAA, 8'hEE, 8'hFA, 8'hFE, 8'hFF: return 1'b1;
      default:                                  return 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/ps2_scancode_filter_if.sv
// Key-event channel from the filter to the keyboard reader.
// Head event is visible combinationally from the FIFO head.
// Valid/ready: an event is consumed when key_valid and key_ready are both high.
interface ps2_scancode_filter_if;
  logic       key_valid;
  logic       key_ready;
  logic [7:0] key_code;
  logic       key_ext;

  modport master (output key_valid, output key_code, output key_ext, input key_ready);
  modport slave  (input key_valid, input key_code, input key_ext, output key_ready);
endinterface

// File: rtl/key_event_fifo.sv
// Event FIFO, DEPTH entries of key_evt_t, with synchronous flush.
// Push in cycle N is visible at the head in cycle N+1.
// Push while full without a pop is dropped and flagged by a one-cycle overflow pulse.
module key_event_fifo
  import ps2_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic     clk,
  input  logic     resetn,
  input  logic     flush,
  input  logic     push,
  input  key_evt_t push_dat,
  input  logic     pop,
  output key_evt_t pop_dat,
  output logic     full,
  output logic     empty,
  output logic     overflow
);

  localparam int PW = $clog2(DEPTH);

  logic [PW:0] wr_ptr, rd_ptr;
  key_evt_t    mem [DEPTH];
  logic        pop_ok, wr_ok;

  // Extra pointer MSB distinguishes full from empty when the indices match
  assign empty   = (wr_ptr == rd_ptr);
  assign full    = (wr_ptr[PW] != rd_ptr[PW]) && (wr_ptr[PW-1:0] == rd_ptr[PW-1:0]);
  assign pop_ok  = pop & ~empty;
  // A pop in the same cycle frees the slot, so a full FIFO still accepts
  assign wr_ok   = push & (~full | pop_ok);
  // Head reads as zero when empty so outputs are clean after reset
  assign pop_dat = empty ? '0 : mem[rd_ptr[PW-1:0]];

  // Storage write; contents need no reset because reads are gated by empty
  always_ff @(posedge clk) begin
    if (wr_ok && !flush) mem[wr_ptr[PW-1:0]] <= push_dat;
  end

  // Pointer update and overflow pulse
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      overflow <= 1'b0;
    end else if (flush) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      overflow <= 1'b0;
    end else begin
      if (wr_ok)  wr_ptr <= wr_ptr + 1'b1;
      if (pop_ok) rd_ptr <= rd_ptr + 1'b1;
      overflow <= push & full & ~pop_ok;
    end
  end

endmodule

// File: rtl/ps2_scancode_filter.sv
// Turns the raw PS/2 set-2 byte stream into one make event per key press.
// Byte strobe in cycle N gives key_valid in cycle N+1 when the FIFO was empty.
// Valid/ready on key_if; overflow pulses when a make meets a full FIFO with no pop.
module ps2_scancode_filter
  import ps2_pkg::*;
#(
  parameter int DEPTH           = 4,
  parameter int TIMEOUT_CYCLES  = 1000000,
  parameter int SUPPRESS_REPEAT = 1
) (
  input  logic                  clk,
  input  logic                  resetn,
  input  logic [7:0]            received_data,
  input  logic                  received_data_en,
  input  logic                  flush,
  ps2_scancode_filter_if.master key_if,
  output logic                  overflow,
  output logic                  protocol_error
);

  localparam int            TW   = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [TW-1:0] TMAX = TW'(TIMEOUT_CYCLES - 1);

  state_t      state, nxt;
  logic [TW-1:0] tcnt;
  logic        held_vld;
  key_evt_t    held;
  key_evt_t    evt, head;
  logic        strb, mk_vld, brk_vld, evt_ext, err, hit, mk_acc;
  logic        fifo_full, fifo_empty, pop;

  // A byte arriving together with flush is discarded outright
  assign strb = received_data_en & ~flush;
  assign evt  = {evt_ext, received_data};
  assign hit  = held_vld && (held == evt);
  assign mk_acc = mk_vld && !((SUPPRESS_REPEAT != 0) && hit);

  // Decode the incoming byte against the current prefix state
  always_comb begin
    nxt     = state;
    mk_vld  = 1'b0;
    brk_vld = 1'b0;
    evt_ext = 1'b0;
    err     = 1'b0;
    if (strb) begin
      case (state)
        IDLE: begin
          if (received_data == PS2_EXT)      nxt = EXT;
          else if (received_data == PS2_BRK) nxt = BRK;
          else                               mk_vld = ~is_special(received_data);
        end
        EXT: begin
          if (received_data == PS2_BRK)      nxt = EXT_BRK;
          else if (received_data == PS2_EXT) nxt = EXT;
          else begin
            nxt     = IDLE;
            mk_vld  = ~is_special(received_data);
            evt_ext = 1'b1;
          end
        end
        BRK, EXT_BRK: begin
          nxt = IDLE;
          if (received_data == PS2_EXT || received_data == PS2_BRK || is_special(received_data)) begin
            err = 1'b1;
          end else begin
            brk_vld = 1'b1;
            evt_ext = (state == EXT_BRK);
          end
        end
        default: nxt = IDLE;
      endcase
    end else if (state != IDLE && tcnt == TMAX) begin
      // A stalled prefix is abandoned silently
      nxt = IDLE;
    end
  end

  // Prefix FSM, timeout counter, held-key tracker and error pulse
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state          <= IDLE;
      tcnt           <= '0;
      held_vld       <= 1'b0;
      held           <= '0;
      protocol_error <= 1'b0;
    end else begin
      protocol_error <= err;
      if (flush) begin
        state <= IDLE;
        tcnt  <= '0;
      end else begin
        state <= nxt;
        if (received_data_en || state == IDLE || nxt == IDLE) tcnt <= '0;
        else                                                  tcnt <= tcnt + 1'b1;
      end
      // Newest make is the held key; only its own break releases it
      if (mk_acc) begin
        held_vld <= 1'b1;
        held     <= evt;
      end else if (brk_vld && hit) begin
        held_vld <= 1'b0;
      end
    end
  end

  assign pop = key_if.key_valid & key_if.key_ready;

  key_event_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk      (clk),
    .resetn   (resetn),
    .flush    (flush),
    .push     (mk_acc),
    .push_dat (evt),
    .pop      (pop),
    .pop_dat  (head),
    .full     (fifo_full),
    .empty    (fifo_empty),
    .overflow (overflow)
  );

  assign key_if.key_valid = ~fifo_empty;
  assign key_if.key_code  = head.code;
  assign key_if.key_ext   = head.ext;

endmodule
